// File: rtl/gsensor_spi_master.sv
// gsensor_spi_master: SPI mode-3 master for the ADXL345 accelerometer.
// One request = one 16-bit frame {R/W#, MB, addr[5:0], data[7:0]}, MSB first.
// Frame sequence: IDLE -> SETUP -> SHIFT (16 bits) -> HOLD -> GAP -> IDLE.
// Every interface output is driven straight from a flop.
module gsensor_spi_master #(
  parameter int CLK_DIV = 5,  // clk cycles per SCLK half-period, >= 1
  parameter int ADDR_W  = 6   // ADXL345 register address width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rdata,
  output logic              spi_cs_,
  output logic              spi_sclk,
  output logic              spi_sdi,
  input  logic              spi_sdo
);

  // Half-period counter runs 0..CLK_DIV-1.
  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] HC_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] HC_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HC_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [3:0]       BIT_LAST = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  // Builds the 16-bit ADXL345 single-register frame. MB (multi-byte) is
  // always 0; read frames carry a zero data byte.
  function automatic logic [15:0] build_frame(input logic f_we,
                                              input logic [ADDR_W-1:0] f_addr,
                                              input logic [7:0] f_wdata);
    logic [7:0] data_byte;
    if (f_we) begin
      data_byte = f_wdata;
    end else begin
      data_byte = 8'h00;
    end
    return {~f_we, 1'b0, f_addr, data_byte};
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;     // half-period cycle counter
  logic [3:0]       bit_q, bit_d;       // index of the bit on the wire, 0..15
  logic             phase_q, phase_d;   // 0 = SCLK low half, 1 = SCLK high half
  logic [14:0]      shreg_q, shreg_d;   // frame bits not yet placed on MOSI
  logic [7:0]       rx_q, rx_d;         // MISO history; last 8 samples = read byte
  logic             we_q, we_d;         // access type latched at accept
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             sdi_q, sdi_d;

  logic [15:0]      frame_s;
  logic             half_end_s;

  assign frame_s    = build_frame(we, addr, wdata);
  assign half_end_s = (hcnt_q == HC_LAST);

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    sdi_d   = sdi_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          // Accept: latch the frame, drop CS and present bit 15 on MOSI
          // for the whole SETUP period.
          state_d = S_SETUP;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          sclk_d  = 1'b1;
          sdi_d   = frame_s[15];
          shreg_d = frame_s[14:0];
          we_d    = we;
          hcnt_d  = HC_ZERO;
          bit_d   = 4'd0;
          phase_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SETUP: begin
        if (half_end_s) begin
          state_d = S_SHIFT;
          hcnt_d  = HC_ZERO;
          bit_d   = 4'd0;
          phase_d = 1'b0;
          sclk_d  = 1'b0;
        end else begin
          hcnt_d  = hcnt_q + HC_ONE;
        end
      end

      S_SHIFT: begin
        if (!half_end_s) begin
          hcnt_d = hcnt_q + HC_ONE;
        end else begin
          hcnt_d = HC_ZERO;
          if (!phase_q) begin
            // Rising edge: MISO is source-synchronous to SCLK, so it is
            // captured on the same clk edge that drives SCLK high.
            sclk_d  = 1'b1;
            phase_d = 1'b1;
            rx_d    = {rx_q[6:0], spi_sdo};
          end else if (bit_q == BIT_LAST) begin
            // 16th high phase complete; SCLK stays high into HOLD.
            state_d = S_HOLD;
            phase_d = 1'b0;
          end else begin
            // Falling edge: advance MOSI to the next frame bit.
            bit_d   = bit_q + 4'd1;
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            sdi_d   = shreg_q[14];
            shreg_d = {shreg_q[13:0], 1'b0};
          end
        end
      end

      S_HOLD: begin
        if (half_end_s) begin
          state_d = S_GAP;
          hcnt_d  = HC_ZERO;
          cs_d    = 1'b1;
          sdi_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) begin
            rdata_d = rx_q;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          hcnt_d = hcnt_q + HC_ONE;
        end
      end

      S_GAP: begin
        // CS deassert time before another frame may start.
        if (half_end_s) begin
          state_d = S_IDLE;
          hcnt_d  = HC_ZERO;
          busy_d  = 1'b0;
        end else begin
          hcnt_d = hcnt_q + HC_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        hcnt_d  = HC_ZERO;
        bit_d   = 4'd0;
        phase_d = 1'b0;
        busy_d  = 1'b0;
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
        sdi_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hcnt_q  <= HC_ZERO;
      bit_q   <= 4'd0;
      phase_q <= 1'b0;
      shreg_q <= 15'd0;
      rx_q    <= 8'h00;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      sdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      sdi_q   <= sdi_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign spi_cs_  = cs_q;
  assign spi_sclk = sclk_q;
  assign spi_sdi  = sdi_q;

endmodule

// File: tb/tb_gsensor_spi_master.sv
// Testbench for gsensor_spi_master: two instances (CLK_DIV=5 and CLK_DIV=1),
// an ADXL345-like slave per instance, a register-file reference model and a
// scoreboard checked at every done pulse.
module tb_gsensor_spi_master;

  localparam int DIV0 = 5;
  localparam int DIV1 = 1;

  typedef struct {
    int          k;
    logic [15:0] frame;
    logic [7:0]  rd;
    int          spacing;  // expected done-to-done distance, 0 = unchecked
  } exp_t;

  logic       clk;
  logic       rst_a   [2];
  logic       req_a   [2];
  logic       we_a    [2];
  logic [5:0] addr_a  [2];
  logic [7:0] wdata_a [2];
  logic       busy_a  [2];
  logic       done_a  [2];
  logic [7:0] rdata_a [2];
  logic       cs_a    [2];
  logic       sclk_a  [2];
  logic       sdi_a   [2];
  logic       sdo_a   [2];

  gsensor_spi_master #(.CLK_DIV(DIV0), .ADDR_W(6)) u_dut_div5 (
    .clk(clk), .rst(rst_a[0]), .req(req_a[0]), .we(we_a[0]), .addr(addr_a[0]),
    .wdata(wdata_a[0]), .busy(busy_a[0]), .done(done_a[0]), .rdata(rdata_a[0]),
    .spi_cs_(cs_a[0]), .spi_sclk(sclk_a[0]), .spi_sdi(sdi_a[0]), .spi_sdo(sdo_a[0])
  );

  gsensor_spi_master #(.CLK_DIV(DIV1), .ADDR_W(6)) u_dut_div1 (
    .clk(clk), .rst(rst_a[1]), .req(req_a[1]), .we(we_a[1]), .addr(addr_a[1]),
    .wdata(wdata_a[1]), .busy(busy_a[1]), .done(done_a[1]), .rdata(rdata_a[1]),
    .spi_cs_(cs_a[1]), .spi_sclk(sclk_a[1]), .spi_sdi(sdi_a[1]), .spi_sdo(sdo_a[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: register file contents and last read value per instance.
  logic [7:0] model_mem [2][64];
  logic [7:0] model_rd  [2];
  // Slave-side register file (environment, updated only by MOSI traffic).
  logic [7:0] slave_mem [2][64];

  // Monitor bookkeeping.
  int          cyc;
  int          bcnt [2], csl [2], rises [2], sl_bits [2];
  int          done_cnt [2], last_done [2], inv_err [2];
  logic [15:0] sl_frame [2];
  logic [7:0]  sl_cmd [2];
  logic        prev_busy [2], prev_cs [2], prev_sclk [2], rst_pend [2];

  function automatic int div_of(input int k);
    return (k == 0) ? DIV0 : DIV1;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s div=%0d: got 0x%0h, expected 0x%0h", name, div_of(k), act, exp);
    end
  endtask

  // One negedge sample of instance k: slave behaviour plus scoreboard checks.
  task automatic mon_step(input int k);
    int         d;
    logic [7:0] b;
    exp_t       e;
    d = div_of(k);
    if (rst_pend[k] && !rst_a[k]) begin
      check("reset state {busy,done,cs,sclk,sdi,rdata}", k,
            {19'd0, busy_a[k], done_a[k], cs_a[k], sclk_a[k], sdi_a[k], rdata_a[k]},
            {19'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
      rst_pend[k]  = 1'b0;
      bcnt[k]      = 0;
      csl[k]       = 0;
      rises[k]     = 0;
      sl_bits[k]   = 0;
      prev_busy[k] = 1'b0;
      prev_cs[k]   = 1'b1;
      prev_sclk[k] = 1'b1;
      return;
    end
    if (rst_a[k]) begin
      rst_pend[k] = 1'b1;
      return;
    end

    if (busy_a[k] && !prev_busy[k]) begin
      bcnt[k]  = 0;
      csl[k]   = 0;
      rises[k] = 0;
    end
    if (busy_a[k]) bcnt[k]++;
    if (!cs_a[k]) csl[k]++;

    // Slave: frame start, MOSI capture on rising SCLK, MISO drive on falling SCLK.
    if (!cs_a[k] && prev_cs[k]) begin
      sl_bits[k]  = 0;
      sl_frame[k] = 16'h0000;
    end
    if (!cs_a[k] && sclk_a[k] && !prev_sclk[k]) begin
      sl_frame[k] = {sl_frame[k][14:0], sdi_a[k]};
      sl_bits[k]++;
      rises[k]++;
      if (sl_bits[k] == 8) sl_cmd[k] = sl_frame[k][7:0];
      if (sl_bits[k] == 16 && !sl_frame[k][15]) slave_mem[k][sl_frame[k][13:8]] = sl_frame[k][7:0];
    end
    if (!cs_a[k] && !sclk_a[k] && prev_sclk[k]) begin
      if (sl_bits[k] >= 8 && sl_cmd[k][7]) begin
        b = slave_mem[k][sl_cmd[k][5:0]];
        sdo_a[k] = b[3'(15 - sl_bits[k])];
      end else begin
        sdo_a[k] = 1'($urandom);
      end
    end

    // SCLK must stay high and MOSI low whenever CS is deasserted.
    if (cs_a[k]) begin
      if (sclk_a[k] !== prev_sclk[k] || sclk_a[k] !== 1'b1) inv_err[k]++;
      if (sdi_a[k] !== 1'b0) inv_err[k]++;
    end

    if (done_a[k]) begin
      done_cnt[k]++;
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected done div=%0d: got done pulse, expected none", d);
      end else begin
        e = sbq.pop_front();
        check("done busy-cycle", k, bcnt[k], 34 * d + 1);
        check("cs low cycles", k, csl[k], 34 * d);
        check("sclk rising edges", k, rises[k], 16);
        check("mosi frame", k, sl_frame[k], e.frame);
        check("rdata at done", k, rdata_a[k], e.rd);
        if (e.spacing != 0) check("done spacing", k, cyc - last_done[k], e.spacing);
      end
      last_done[k] = cyc;
    end

    if (!busy_a[k] && prev_busy[k]) check("busy length", k, bcnt[k], 35 * d);

    prev_busy[k] = busy_a[k];
    prev_cs[k]   = cs_a[k];
    prev_sclk[k] = sclk_a[k];
  endtask

  // Monitor / slave process, sampling on the falling clk edge.
  initial begin
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      sdo_a[k] = 1'b0;
      bcnt[k] = 0; csl[k] = 0; rises[k] = 0; sl_bits[k] = 0;
      done_cnt[k] = 0; last_done[k] = 0; inv_err[k] = 0;
      sl_frame[k] = 16'h0000; sl_cmd[k] = 8'h00;
      prev_busy[k] = 1'b0; prev_cs[k] = 1'b1; prev_sclk[k] = 1'b1; rst_pend[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) mon_step(k);
    end
  end

  // Issue one access; pushes the expected result once the DUT accepts it.
  task automatic issue(input int k, input logic w, input logic [5:0] a, input logic [7:0] d,
                       input int spacing, input bit keep);
    int   g;
    exp_t e;
    g = 0;
    while (busy_a[k] === 1'b1 && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 2000) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue timeout div=%0d: busy stuck high, expected idle", div_of(k));
      return;
    end
    we_a[k] = w; addr_a[k] = a; wdata_a[k] = d; req_a[k] = 1'b1;
    @(posedge clk); #1;
    e.k = k;
    e.frame = {~w, 1'b0, a, (w ? d : 8'h00)};
    e.spacing = spacing;
    if (w) begin
      e.rd = model_rd[k];
      model_mem[k][a] = d;
    end else begin
      e.rd = model_mem[k][a];
      model_rd[k] = e.rd;
    end
    sbq.push_back(e);
    check("busy after accept", k, busy_a[k], 1);
    if (!keep) req_a[k] = 1'b0;
    // Input changes while busy must not affect the frame in flight.
    we_a[k] = 1'($urandom); addr_a[k] = 6'($urandom); wdata_a[k] = 8'($urandom);
  endtask

  task automatic wait_idle(input int k);
    int g;
    g = 0;
    while ((busy_a[k] === 1'b1 || sbq.size() != 0) && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle timeout div=%0d: %0d entries pending, expected 0", div_of(k), sbq.size());
      sbq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // A request with different contents while the current frame is running.
  task automatic poke(input int k);
    repeat (10 * div_of(k)) @(posedge clk);
    #1;
    req_a[k] = 1'b1; we_a[k] = 1'($urandom); addr_a[k] = 6'($urandom); wdata_a[k] = 8'($urandom);
    @(posedge clk); #1;
    check("busy during ignored req", k, busy_a[k], 1);
    req_a[k] = 1'b0;
  endtask

  // Start a read, reset after 8 rising SCLK edges, and confirm no done follows.
  task automatic reset_mid(input int k);
    int g;
    int dc;
    issue(k, 1'b0, 6'h00, 8'h00, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    g = 0;
    while (rises[k] < 8 && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 1000) begin
      n_tests++;
      n_fail++;
      $display("FAIL reset_mid timeout div=%0d: %0d rising edges, expected 8", div_of(k), rises[k]);
    end
    rst_a[k] = 1'b1;
    sbq.delete();
    model_rd[k] = 8'h00;
    dc = done_cnt[k];
    @(posedge clk); #1;
    rst_a[k] = 1'b0;
    check("busy after reset", k, busy_a[k], 0);
    repeat (40 * div_of(k)) @(posedge clk);
    #1;
    check("no done after reset", k, done_cnt[k], dc);
  endtask

  task automatic random_txn(input int k, input int n);
    logic       w;
    logic [5:0] a;
    for (int i = 0; i < n; i++) begin
      w = 1'($urandom);
      a = w ? 6'($urandom_range(63, 1)) : 6'($urandom_range(63, 0));
      issue(k, w, a, 8'($urandom), 0, 1'b0);
      if ($urandom_range(2, 0) == 0) poke(k);
      wait_idle(k);
    end
  endtask

  // Stimulus sequence.
  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_a[k] = 1'b1; req_a[k] = 1'b0; we_a[k] = 1'b0; addr_a[k] = 6'h00; wdata_a[k] = 8'h00;
      model_rd[k] = 8'h00;
      for (int i = 0; i < 64; i++) begin
        model_mem[k][i] = 8'($urandom);
        slave_mem[k][i] = model_mem[k][i];
      end
      model_mem[k][0] = 8'hE5;
      slave_mem[k][0] = 8'hE5;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_a[0] = 1'b0;
    rst_a[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // CLK_DIV = 5
    issue(0, 1'b1, 6'h2D, 8'h08, 0, 1'b0); wait_idle(0);
    issue(0, 1'b0, 6'h00, 8'h00, 0, 1'b0); wait_idle(0);
    issue(0, 1'b0, 6'h2D, 8'h00, 0, 1'b0); wait_idle(0);
    issue(0, 1'b1, 6'h31, 8'($urandom), 0, 1'b0); poke(0); wait_idle(0);
    reset_mid(0);
    issue(0, 1'b0, 6'h00, 8'h00, 0, 1'b0); wait_idle(0);
    issue(0, 1'b0, 6'h00, 8'h00, 0, 1'b1);
    issue(0, 1'b0, 6'h32, 8'h00, 35 * DIV0 + 1, 1'b0); wait_idle(0);
    random_txn(0, 10);

    // CLK_DIV = 1
    issue(1, 1'b1, 6'h2D, 8'h08, 0, 1'b0); wait_idle(1);
    issue(1, 1'b0, 6'h2D, 8'h00, 0, 1'b0); wait_idle(1);
    issue(1, 1'b0, 6'h00, 8'h00, 0, 1'b0); poke(1); wait_idle(1);
    issue(1, 1'b0, 6'h00, 8'h00, 0, 1'b1);
    issue(1, 1'b0, 6'h32, 8'h00, 35 * DIV1 + 1, 1'b0); wait_idle(1);
    reset_mid(1);
    random_txn(1, 6);

    check("scoreboard drained", 0, sbq.size(), 0);
    check("cs-high sclk/sdi violations", 0, inv_err[0], 0);
    check("cs-high sclk/sdi violations", 1, inv_err[1], 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
